// File: rtl/ex_wb_pkg.sv
// Shared types and constants for the execute/write-back stage.
// FSM state encoding, flag bit positions and default widths.
package ex_wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RB_AW_DEF  = 5;

    // Bit positions inside the 4-bit flags word
    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } ex_wb_state_t;

endpackage

// File: rtl/ex_wb_flags.sv
// Four-bit ALU flags register (O, S, C, Z).
// Synchronous active-high reset, load on WE.
module flags_register (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WE,
    input  logic [3:0] D,
    output logic [3:0] Q
);

    // Flags hold until an instruction writes them
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= 4'b0000;
        end else if (WE) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/ex_wb.sv
// Execute/write-back stage: register-bank write, flags, jump pulse.
// Define EX_WB_FWD_EN to drive the forwarding port; otherwise it is 0.
module ex_wb
    import ex_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RB_AW  = RB_AW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] dm_Q,
    input  logic              alu_O,
    input  logic              alu_S,
    input  logic              alu_C,
    input  logic              alu_Z,
    input  logic              tf_out,
    input  logic              uc_S_MXWB,
    input  logic              uc_WE_RB,
    input  logic              uc_WE_FLAGS,
    input  logic              uc_JUMP,
    input  logic [RB_AW-1:0]  uc_RD,
    input  logic              flush,
    output logic              rb_WE,
    output logic [RB_AW-1:0]  rb_WC,
    output logic [DATA_W-1:0] rb_D,
    output logic              rf_O,
    output logic              rf_S,
    output logic              rf_C,
    output logic              rf_Z,
    output logic              pc_jump,
    output logic              fwd_valid,
    output logic [RB_AW-1:0]  fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    ex_wb_state_t     state;
    ex_wb_state_t     state_nxt;
    logic             accept;
    logic             ld_we;
    logic [RB_AW-1:0] ld_rd;
    logic             flags_we;
    logic [3:0]       flags_d;
    logic [3:0]       flags_q;

    assign in_ready = (state == RUN);
    assign accept   = in_valid && in_ready && !flush;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: loads stall one cycle; LOAD_WAIT always exits
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (accept && uc_S_MXWB) begin
                    state_nxt = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Write-back port, jump pulse and pending-load destination
    always_ff @(posedge CLK) begin
        if (RST) begin
            rb_WE   <= 1'b0;
            rb_WC   <= '0;
            rb_D    <= '0;
            pc_jump <= 1'b0;
            ld_we   <= 1'b0;
            ld_rd   <= '0;
        end else begin
            rb_WE   <= 1'b0;
            pc_jump <= 1'b0;
            if (accept) begin
                pc_jump <= uc_JUMP && tf_out;
                if (uc_S_MXWB) begin
                    ld_we <= uc_WE_RB;
                    ld_rd <= uc_RD;
                end else begin
                    rb_WE <= uc_WE_RB;
                    rb_WC <= uc_RD;
                    rb_D  <= alu_result;
                end
            end
            if (state == LOAD_WAIT && !flush) begin
                rb_WE <= ld_we;
                rb_WC <= ld_rd;
                rb_D  <= dm_Q;
            end
        end
    end

    // Flags update only for accepted non-load instructions
    always_comb begin
        flags_d         = 4'b0000;
        flags_d[FLAG_O] = alu_O;
        flags_d[FLAG_S] = alu_S;
        flags_d[FLAG_C] = alu_C;
        flags_d[FLAG_Z] = alu_Z;
        flags_we        = accept && uc_WE_FLAGS && !uc_S_MXWB;
    end

    flags_register u_flags (
        .CLK (CLK),
        .RST (RST),
        .WE  (flags_we),
        .D   (flags_d),
        .Q   (flags_q)
    );

    assign rf_O = flags_q[FLAG_O];
    assign rf_S = flags_q[FLAG_S];
    assign rf_C = flags_q[FLAG_C];
    assign rf_Z = flags_q[FLAG_Z];

`ifdef EX_WB_FWD_EN
    // While a load is pending, expose its destination but no data
    always_comb begin
        fwd_valid = rb_WE;
        fwd_addr  = rb_WC;
        fwd_data  = rb_D;
        if (state == LOAD_WAIT) begin
            fwd_valid = 1'b0;
            fwd_addr  = ld_rd;
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

endmodule
